// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths, bypass select encodings and mult/div FSM states
package pipe_pkg;

  localparam int ADDR_W = 5;

  localparam logic [1:0] BYP_XM = 2'd0;
  localparam logic [1:0] BYP_MW = 2'd1;
  localparam logic [1:0] BYP_RF = 2'd2;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } md_state_e;

endpackage

// File: rtl/byp_match.sv
// rtl/byp_match.sv - source-vs-stage destination comparator
// A hit needs a live source, a writing stage and a non-zero destination.
module byp_match #(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] src,
  input  logic              uses,
  input  logic [ADDR_W-1:0] dst,
  input  logic              rwe,
  output logic              hit
);

  assign hit = uses && rwe && (dst != '0) && (src == dst);

endmodule

// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - operand/store-data bypass selects, load-use and mult/div hazards
// Tracks one in-flight mult/div op and counts stalled cycles with saturation.
module hazard_fwd_unit #(
  parameter int ADDR_W       = pipe_pkg::ADDR_W,
  parameter int MD_TIMEOUT   = 40,
  parameter int TMO_W        = 6,
  parameter int CNT_W        = 16,
  parameter int STORE_BYP_EN = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] fd_rs,
  input  logic [ADDR_W-1:0] fd_rt,
  input  logic [ADDR_W-1:0] fd_rd,
  input  logic              fd_uses_rs,
  input  logic              fd_uses_rt,
  input  logic              fd_rwe,
  input  logic              fd_is_store,
  input  logic              fd_is_md,
  input  logic [ADDR_W-1:0] dx_rs,
  input  logic [ADDR_W-1:0] dx_rt,
  input  logic [ADDR_W-1:0] dx_rd,
  input  logic              dx_uses_rs,
  input  logic              dx_uses_rt,
  input  logic              dx_rwe,
  input  logic              dx_is_load,
  input  logic              dx_is_md,
  input  logic [ADDR_W-1:0] xm_rd,
  input  logic [ADDR_W-1:0] xm_rt,
  input  logic              xm_rwe,
  input  logic              xm_is_store,
  input  logic [ADDR_W-1:0] mw_rd,
  input  logic              mw_rwe,
  input  logic              md_ready,
  output logic [1:0]        byp_sel_a,
  output logic [1:0]        byp_sel_b,
  output logic              byp_sel_mem_data,
  output logic              stall,
  output logic              bubble_dx,
  output logic              md_busy,
  output logic              md_done,
  output logic              md_timeout,
  output logic [ADDR_W-1:0] md_rd,
  output logic [CNT_W-1:0]  stall_cycles
);
  import pipe_pkg::*;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MD_TIMEOUT - 1);

  logic rs_xm, rs_mw, rt_xm, rt_mw, sd_mw;

  byp_match #(.ADDR_W(ADDR_W)) u_rs_xm (.src(dx_rs), .uses(dx_uses_rs), .dst(xm_rd), .rwe(xm_rwe), .hit(rs_xm));
  byp_match #(.ADDR_W(ADDR_W)) u_rs_mw (.src(dx_rs), .uses(dx_uses_rs), .dst(mw_rd), .rwe(mw_rwe), .hit(rs_mw));
  byp_match #(.ADDR_W(ADDR_W)) u_rt_xm (.src(dx_rt), .uses(dx_uses_rt), .dst(xm_rd), .rwe(xm_rwe), .hit(rt_xm));
  byp_match #(.ADDR_W(ADDR_W)) u_rt_mw (.src(dx_rt), .uses(dx_uses_rt), .dst(mw_rd), .rwe(mw_rwe), .hit(rt_mw));
  byp_match #(.ADDR_W(ADDR_W)) u_sd_mw (.src(xm_rt), .uses(xm_is_store), .dst(mw_rd), .rwe(mw_rwe), .hit(sd_mw));

  // The younger X/M result always wins over M/W.
  assign byp_sel_a        = rs_xm ? BYP_XM : (rs_mw ? BYP_MW : BYP_RF);
  assign byp_sel_b        = rt_xm ? BYP_XM : (rt_mw ? BYP_MW : BYP_RF);
  assign byp_sel_mem_data = sd_mw;

  md_state_e         state, state_n;
  logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_n;
  logic [ADDR_W-1:0] md_rd_n;
  logic              done_n, timeout_n;
  logic              load_live, store_data_only, load_haz, md_live, md_nz, md_haz;

  assign load_live       = dx_is_load && dx_rwe && (dx_rd != '0);
  assign store_data_only = (STORE_BYP_EN != 0) && fd_is_store;
  assign load_haz        = load_live &&
                           ((fd_uses_rs && (fd_rs == dx_rd)) ||
                            (fd_uses_rt && (fd_rt == dx_rd) && !store_data_only));

  assign md_live = (state == MD_WAIT);
  assign md_nz   = (md_rd != '0);
  assign md_haz  = md_live &&
                   (fd_is_md ||
                    (md_nz && fd_uses_rs && (fd_rs == md_rd)) ||
                    (md_nz && fd_uses_rt && (fd_rt == md_rd)) ||
                    (md_nz && fd_rwe && (fd_rd == md_rd)));

  assign stall     = load_haz | md_haz;
  assign bubble_dx = stall;
  assign md_busy   = md_live;

  always_comb begin
    state_n   = state;
    tmo_cnt_n = tmo_cnt;
    md_rd_n   = md_rd;
    done_n    = 1'b0;
    timeout_n = 1'b0;
    case (state)
      RUN: begin
        if (dx_is_md && !stall) begin
          state_n   = MD_WAIT;
          md_rd_n   = dx_rd;
          tmo_cnt_n = '0;
        end
      end
      MD_WAIT: begin
        // A result arriving on the timeout edge still counts as a normal completion.
        if (md_ready) begin
          state_n = RUN;
          done_n  = 1'b1;
        end else if (tmo_cnt == TMO_LAST) begin
          state_n   = RUN;
          done_n    = 1'b1;
          timeout_n = 1'b1;
        end else begin
          tmo_cnt_n = tmo_cnt + 1'b1;
        end
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      tmo_cnt      <= '0;
      md_rd        <= '0;
      md_done      <= 1'b0;
      md_timeout   <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state      <= state_n;
      tmo_cnt    <= tmo_cnt_n;
      md_rd      <= md_rd_n;
      md_done    <= done_n;
      md_timeout <= timeout_n;
      if (stall && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
    end
  end

endmodule
